// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single field widths,
// canonical constants and the divider control state type.
package fpu_pkg;

    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int EXP_BIAS = 127;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] PINF = 32'h7F80_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DIV   = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } fdiv_state_t;

endpackage

// File: rtl/fpu_round_rne.sv
// Round-to-nearest-even on a 25-bit quotient (24 mantissa + guard),
// with exponent overflow/underflow resolution. Shared by fdiv/fmul/fsqrt.
module fpu_round_rne
    import fpu_pkg::*;
(
    input  logic [MAN_W+1:0]  q_i,
    input  logic              sticky_i,
    input  logic signed [9:0] ez_i,
    input  logic              sy_i,
    output logic [31:0]       y_o,
    output logic              ovf_o
);

    logic              up;
    logic [MAN_W+1:0]  m_sum;
    logic [MAN_W:0]    man;
    logic signed [9:0] ez_r;

    always_comb begin
        up    = q_i[0] & (sticky_i | q_i[1]);
        m_sum = {1'b0, q_i[MAN_W+1:1]}
              + {{(MAN_W+1){1'b0}}, up};
        // all-ones mantissa rounding up wraps to 1.0 of the next binade
        if (m_sum[MAN_W+1]) begin
            man  = m_sum[MAN_W+1:1];
            ez_r = ez_i + 10'sd1;
        end else begin
            man  = m_sum[MAN_W:0];
            ez_r = ez_i;
        end
        ovf_o = 1'b0;
        y_o   = {sy_i, ez_r[EXP_W-1:0], man[MAN_W-1:0]};
        if (ez_r >= 10'sd255) begin
            y_o   = {sy_i, PINF[30:0]};
            ovf_o = 1'b1;
        end else if (ez_r <= 10'sd0) begin
            y_o = {sy_i, 31'd0};
        end
    end

endmodule

// File: rtl/fdiv_iter.sv
// Multi-cycle IEEE-754 single divider: restoring shift-subtract
// mantissa division followed by one RNE rounding stage.
module fdiv_iter
    import fpu_pkg::*;
#(
    parameter int RADIX_BITS = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        ovf,
    output logic        dz
);

    localparam int N  = 25 / RADIX_BITS;
    localparam int QW = MAN_W + 2;
    localparam int RW = MAN_W + 3;
    localparam logic [4:0] CNT_INIT = 5'(N - 1);

    fdiv_state_t state_q, state_d;

    logic [4:0]        cnt_q, cnt_d;
    logic [RW-1:0]     r_q, r_d;
    logic [MAN_W:0]    mb_q, mb_d;
    logic [QW-1:0]     q_q, q_d;
    logic signed [9:0] ez_q, ez_d;
    logic              sy_q, sy_d;
    logic [31:0]       y_q, y_d;
    logic              ovf_q, ovf_d;
    logic              dz_q, dz_d;

    logic [EXP_W-1:0] e1, e2;
    logic [MAN_W-1:0] f1, f2;
    logic             z1, z2, inf1, inf2, nan1, nan2;
    logic             sy, adj, accept;
    logic [MAN_W:0]   ma, mb;
    logic [RW-1:0]    r_init;
    logic signed [9:0] ez_init;

    logic        spec, spec_dz;
    logic [31:0] spec_y;

    logic [RW-1:0] r_n;
    logic [QW-1:0] q_n;
    logic          qb;

    logic [31:0] rnd_y;
    logic        rnd_ovf;

    assign e1   = x1[30:23];
    assign e2   = x2[30:23];
    assign f1   = x1[22:0];
    assign f2   = x2[22:0];
    assign sy   = x1[31] ^ x2[31];
    // denormals (e==0) flush to zero
    assign z1   = (e1 == '0);
    assign z2   = (e2 == '0);
    assign inf1 = (e1 == '1) && (f1 == '0);
    assign inf2 = (e2 == '1) && (f2 == '0);
    assign nan1 = (e1 == '1) && (f1 != '0);
    assign nan2 = (e2 == '1) && (f2 != '0);

    assign ma      = {1'b1, f1};
    assign mb      = {1'b1, f2};
    assign adj     = (ma < mb);
    assign r_init  = adj ? {1'b0, ma, 1'b0} : {2'b00, ma};
    assign ez_init = {2'b00, e1} - {2'b00, e2}
                   + 10'(EXP_BIAS) - {9'd0, adj};

    always_comb begin
        spec    = 1'b1;
        spec_dz = 1'b0;
        spec_y  = QNAN;
        if (nan1 | nan2 | (z1 & z2) | (inf1 & inf2)) begin
            spec_y = QNAN;
        end else if (inf1) begin
            spec_y = {sy, PINF[30:0]};
        end else if (inf2) begin
            spec_y = {sy, 31'd0};
        end else if (z1) begin
            spec_y = {sy, 31'd0};
        end else if (z2) begin
            spec_y  = {sy, PINF[30:0]};
            spec_dz = 1'b1;
        end else begin
            spec = 1'b0;
        end
    end

    always_comb begin
        r_n = r_q;
        q_n = q_q;
        qb  = 1'b0;
        for (int i = 0; i < RADIX_BITS; i++) begin
            qb = (r_n >= {2'b00, mb_q});
            if (qb) begin
                r_n = r_n - {2'b00, mb_q};
            end
            q_n = {q_n[QW-2:0], qb};
            r_n = {r_n[RW-2:0], 1'b0};
        end
    end

    fpu_round_rne u_round (
        .q_i      (q_q),
        .sticky_i (r_q != '0),
        .ez_i     (ez_q),
        .sy_i     (sy_q),
        .y_o      (rnd_y),
        .ovf_o    (rnd_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = spec ? S_DONE : S_DIV;
                end
            end
            S_DIV: begin
                if (cnt_q == '0) begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: state_d = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    assign accept = in_valid & in_ready;

    always_comb begin
        cnt_d = cnt_q;
        r_d   = r_q;
        mb_d  = mb_q;
        q_d   = q_q;
        ez_d  = ez_q;
        sy_d  = sy_q;
        y_d   = y_q;
        ovf_d = ovf_q;
        dz_d  = dz_q;
        if (accept) begin
            sy_d = sy;
            if (spec) begin
                y_d   = spec_y;
                ovf_d = 1'b0;
                dz_d  = spec_dz;
            end else begin
                r_d   = r_init;
                mb_d  = mb;
                q_d   = '0;
                ez_d  = ez_init;
                cnt_d = CNT_INIT;
            end
        end else if (state_q == S_DIV) begin
            r_d = r_n;
            q_d = q_n;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 5'd1;
            end
        end else if (state_q == S_ROUND) begin
            y_d   = rnd_y;
            ovf_d = rnd_ovf;
            dz_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
            r_q   <= '0;
            mb_q  <= '0;
            q_q   <= '0;
            ez_q  <= '0;
            sy_q  <= 1'b0;
            y_q   <= '0;
            ovf_q <= 1'b0;
            dz_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            r_q   <= r_d;
            mb_q  <= mb_d;
            q_q   <= q_d;
            ez_q  <= ez_d;
            sy_q  <= sy_d;
            y_q   <= y_d;
            ovf_q <= ovf_d;
            dz_q  <= dz_d;
        end
    end

    assign y   = y_q;
    assign ovf = ovf_q;
    assign dz  = dz_q;

endmodule

// File: tb/tb_fdiv_iter.sv
// Bench for fdiv_iter: radix-1 and radix-5 instances driven in
// lockstep, checked against an integer-division reference model.
module tb_fdiv_iter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] x1, x2;

    logic        ir1, ov1, ovf1, dz1;
    logic        ir5, ov5, ovf5, dz5;
    logic [31:0] y1, y5;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fdiv_iter #(.RADIX_BITS(1)) dut1 (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (ir1),
        .x1        (x1),
        .x2        (x2),
        .out_valid (ov1),
        .out_ready (out_ready),
        .y         (y1),
        .ovf       (ovf1),
        .dz        (dz1)
    );

    fdiv_iter #(.RADIX_BITS(5)) dut5 (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (ir5),
        .x1        (x1),
        .x2        (x2),
        .out_valid (ov5),
        .out_ready (out_ready),
        .y         (y5),
        .ovf       (ovf5),
        .dz        (dz5)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_spec(input logic [31:0] a,
                                   input logic [31:0] b);
        return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
               (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
    endfunction

    // returns {y, ovf, dz}
    function automatic logic [33:0] ref_div(input logic [31:0] a,
                                            input logic [31:0] b);
        logic   sy, za, zb, ia, ib, na, nb, g, st;
        longint num, qq, rem, main, ma, mb;
        int     ex;
        sy = a[31] ^ b[31];
        za = a[30:23] == 8'h00;
        zb = b[30:23] == 8'h00;
        ia = a[30:23] == 8'hFF && a[22:0] == 0;
        ib = b[30:23] == 8'hFF && b[22:0] == 0;
        na = a[30:23] == 8'hFF && a[22:0] != 0;
        nb = b[30:23] == 8'hFF && b[22:0] != 0;
        if (na || nb || (za && zb) || (ia && ib))
            return {32'h7FC00000, 2'b00};
        if (ia) return {sy, 8'hFF, 23'd0, 2'b00};
        if (ib) return {sy, 31'd0, 2'b00};
        if (za) return {sy, 31'd0, 2'b00};
        if (zb) return {sy, 8'hFF, 23'd0, 2'b01};
        ma  = longint'({1'b1, a[22:0]});
        mb  = longint'({1'b1, b[22:0]});
        num = ma << 25;
        qq  = num / mb;
        rem = num % mb;
        ex  = int'(a[30:23]) - int'(b[30:23]) + 127;
        if (qq >= (64'sd1 <<< 25)) begin
            main = qq >> 2;
            g    = qq[1];
            st   = qq[0] || (rem != 0);
        end else begin
            main = qq >> 1;
            g    = qq[0];
            st   = (rem != 0);
            ex   = ex - 1;
        end
        if (g && (st || main[0])) main = main + 1;
        if (main == (64'sd1 <<< 24)) begin
            main = 64'sd1 <<< 23;
            ex   = ex + 1;
        end
        if (ex >= 255) return {sy, 8'hFF, 23'd0, 2'b10};
        if (ex <= 0) return {sy, 31'd0, 2'b00};
        return {sy, 8'(ex), main[22:0], 2'b00};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 11))
            0: v[30:0]  = 31'd0;
            1: v[30:0]  = {8'hFF, 23'd0};
            2: v[30:23] = 8'hFF;
            3: v[30:23] = 8'h00;
            4, 5: ;
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    task automatic run_op(input string tag,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [33:0] exp,
                          input bit hold);
        bit          sp;
        int          lat, l1, l5;
        logic [31:0] y1h, y5h;
        sp = is_spec(a, b);
        x1 = a;
        x2 = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        l1  = -1;
        l5  = -1;
        lat = 0;
        while ((l1 < 0 || l5 < 0) && lat < 64) begin
            if (ov1 && l1 < 0) l1 = lat;
            if (ov5 && l5 < 0) l5 = lat;
            if (l1 < 0 || l5 < 0) begin
                tick();
                lat++;
            end
        end
        chk({tag, ".lat_r1"}, 32'(l1), sp ? 32'd0 : 32'd26);
        chk({tag, ".lat_r5"}, 32'(l5), sp ? 32'd0 : 32'd6);
        chk({tag, ".y_r1"}, y1, exp[33:2]);
        chk({tag, ".y_r5"}, y5, exp[33:2]);
        chk({tag, ".flags_r1"}, {30'd0, ovf1, dz1}, {30'd0, exp[1:0]});
        chk({tag, ".flags_r5"}, {30'd0, ovf5, dz5}, {30'd0, exp[1:0]});
        if (hold) begin
            y1h = y1;
            y5h = y5;
            in_valid = 1'b1;
            x1 = 32'h40000000;
            repeat (10) begin
                tick();
                chk({tag, ".hold_y_r1"}, y1, y1h);
                chk({tag, ".hold_y_r5"}, y5, y5h);
                chk({tag, ".hold_ir_r1"}, {31'd0, ir1}, 32'd0);
                chk({tag, ".hold_ir_r5"}, {31'd0, ir5}, 32'd0);
                chk({tag, ".hold_ov_r1"}, {31'd0, ov1}, 32'd1);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ".post_ov_r1"}, {31'd0, ov1}, 32'd0);
        chk({tag, ".post_ir_r1"}, {31'd0, ir1}, 32'd1);
        chk({tag, ".post_ov_r5"}, {31'd0, ov5}, 32'd0);
        chk({tag, ".post_ir_r5"}, {31'd0, ir5}, 32'd1);
    endtask

    initial begin
        logic [31:0] a, b;
        rstn      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x1        = '0;
        x2        = '0;
        tick();
        tick();
        rstn = 1'b1;
        chk("rst.ov_r1", {31'd0, ov1}, 32'd0);
        chk("rst.ir_r1", {31'd0, ir1}, 32'd1);
        chk("rst.ov_r5", {31'd0, ov5}, 32'd0);
        chk("rst.ir_r5", {31'd0, ir5}, 32'd1);
        chk("rst.y_r1", y1, 32'd0);
        chk("rst.flags_r1", {30'd0, ovf1, dz1}, 32'd0);

        run_op("6div2", 32'h40C00000, 32'h40000000,
               {32'h40400000, 2'b00}, 1'b0);
        run_op("1div3", 32'h3F800000, 32'h40400000,
               {32'h3EAAAAAB, 2'b00}, 1'b0);
        run_op("1div0", 32'h3F800000, 32'h00000000,
               {32'h7F800000, 2'b01}, 1'b0);
        run_op("0div0", 32'h00000000, 32'h00000000,
               {32'h7FC00000, 2'b00}, 1'b0);
        run_op("infdivinf", 32'h7F800000, 32'h7F800000,
               {32'h7FC00000, 2'b00}, 1'b0);
        run_op("nandiv1", 32'h7FC00001, 32'h3F800000,
               {32'h7FC00000, 2'b00}, 1'b0);
        run_op("ovf", 32'h7F000000, 32'h3E800000,
               {32'h7F800000, 2'b10}, 1'b0);
        run_op("unf", 32'h00800000, 32'h4B000000,
               {32'h00000000, 2'b00}, 1'b0);
        run_op("bp", 32'hC0E00000, 32'h40400000,
               ref_div(32'hC0E00000, 32'h40400000), 1'b1);

        for (int i = 0; i < 40; i++) begin
            a = rnd_fp();
            b = rnd_fp();
            run_op($sformatf("rnd%0d", i), a, b, ref_div(a, b), 1'b0);
        end

        x1 = 32'h40C00000;
        x2 = 32'h40000000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("mrst.ov_r1", {31'd0, ov1}, 32'd0);
        chk("mrst.ir_r1", {31'd0, ir1}, 32'd1);
        chk("mrst.ov_r5", {31'd0, ov5}, 32'd0);
        chk("mrst.ir_r5", {31'd0, ir5}, 32'd1);
        chk("mrst.y_r1", y1, 32'd0);
        repeat (30) begin
            tick();
            chk("mrst.quiet_r1", {31'd0, ov1}, 32'd0);
            chk("mrst.quiet_r5", {31'd0, ov5}, 32'd0);
        end
        run_op("6div2_again", 32'h40C00000, 32'h40000000,
               {32'h40400000, 2'b00}, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
